// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types and constants for the pipeline trace buffer
// Purpose: state encoding, trace entry layout and entry-width helper used by
//    pipe_trace_buffer and its storage array.
// Build option: TRACE_TIMESTAMP_EN adds a 32-bit timestamp field to each entry.
package trace_pkg;

   localparam int TS_W    = 32;
   localparam int PC_W    = 32;
   localparam int INSTR_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_POST  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Entry layout at the default RV32I widths; the top packs the same fields,
   // most significant first, into a flat vector sized by entry_width().
   typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
      logic [TS_W-1:0]    ts;
`endif
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } trace_entry_t;

   function automatic int entry_width(input int xlen, input int ilen);
`ifdef TRACE_TIMESTAMP_EN
      return xlen + ilen + TS_W;
`else
      return xlen + ilen;
`endif
   endfunction

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - DEPTH x W register array, one sync write, one async read
// Ports:
//    clk          write clock, rising edge
//    we/waddr/wdata  synchronous write port
//    raddr/rdata     combinational read port
// Storage is intentionally not reset; contents are meaningless until written.
module trace_ram #(
   parameter int DEPTH = 16,
   parameter int W     = 64
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [W-1:0]             wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [W-1:0]             rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_trace_buffer.sv
// rtl/pipe_trace_buffer.sv - PC-triggered circular trace capture with ordered readout
// Purpose: records {pc, instr} pairs while armed, stops post_cnt entries after
//    a trig_pc match, then replays the window oldest-first.
// Ports:
//    clk, rst (async active-low)
//    enable, arm, trig_pc, post_cnt          capture control
//    cap_valid, cap_pc, cap_instr            capture stream from fetch/decode
//    rd_ready / rd_valid, rd_pc, rd_instr, rd_last   readout handshake
//    state, count, overflow                  status
//    rd_ts                                   only with TRACE_TIMESTAMP_EN
// Build option: TRACE_TIMESTAMP_EN adds a free-running cycle stamp per entry.
module pipe_trace_buffer
   import trace_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int ILEN  = 32,
   parameter int DEPTH = 16,
   parameter int CNTW  = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic                   arm,
   input  logic [XLEN-1:0]        trig_pc,
   input  logic [CNTW-1:0]        post_cnt,
   input  logic                   cap_valid,
   input  logic [XLEN-1:0]        cap_pc,
   input  logic [ILEN-1:0]        cap_instr,
   input  logic                   rd_ready,
   output logic                   rd_valid,
   output logic [XLEN-1:0]        rd_pc,
   output logic [ILEN-1:0]        rd_instr,
   output logic                   rd_last,
   output logic [1:0]             state,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow
`ifdef TRACE_TIMESTAMP_EN
   ,
   output logic [TS_W-1:0]        rd_ts
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = entry_width(XLEN, ILEN);

   state_t          st_q, st_d;
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CNTW-1:0] remaining;
   logic            rd_valid_q;
   logic            wr_en, trig_hit, rd_xfer, rd_load, is_newest, full;
   logic [EW-1:0]   wr_data, rd_data;

   // arm takes priority over a simultaneous capture: that entry is dropped.
   assign wr_en     = enable & cap_valid & ~arm & ((st_q == ST_ARMED) | (st_q == ST_POST));
   assign trig_hit  = wr_en & (st_q == ST_ARMED) & (cap_pc == trig_pc);
   assign full      = (count == CW'(DEPTH));
   // Newest entry always sits just behind the write pointer.
   assign is_newest = (rd_ptr == wr_ptr - AW'(1));
   assign rd_xfer   = rd_valid_q & rd_ready;
   // First cycle in DONE positions rd_ptr on the oldest entry; data goes valid next cycle.
   assign rd_load   = (st_q == ST_DONE) & ~rd_valid_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) st_q <= ST_IDLE;
      else      st_q <= st_d;
   end

   always_comb begin
      st_d = st_q;
      if (arm) begin
         st_d = ST_ARMED;
      end else begin
         case (st_q)
            ST_IDLE:  st_d = ST_IDLE;
            ST_ARMED: if (trig_hit) st_d = (post_cnt == '0) ? ST_DONE : ST_POST;
            ST_POST:  if (wr_en && remaining == CNTW'(1)) st_d = ST_DONE;
            ST_DONE:  if (rd_xfer && is_newest) st_d = ST_IDLE;
            default:  st_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         remaining  <= '0;
         overflow   <= 1'b0;
         rd_valid_q <= 1'b0;
      end else if (arm) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         remaining  <= '0;
         overflow   <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (full) overflow <= 1'b1;
            else      count    <= count + CW'(1);
         end
         if (trig_hit)                        remaining <= post_cnt;
         else if (wr_en && st_q == ST_POST)   remaining <= remaining - CNTW'(1);
         if (rd_load) begin
            rd_ptr     <= full ? wr_ptr : '0;
            rd_valid_q <= 1'b1;
         end else if (rd_xfer) begin
            rd_ptr <= rd_ptr + AW'(1);
            if (is_newest) rd_valid_q <= 1'b0;
         end
      end
   end

`ifdef TRACE_TIMESTAMP_EN
   logic [TS_W-1:0] ts_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ts_q <= '0;
      else      ts_q <= ts_q + TS_W'(1);
   end

   assign wr_data = {ts_q, cap_pc, cap_instr};
   assign rd_ts   = rd_valid_q ? rd_data[XLEN+ILEN +: TS_W] : '0;
`else
   assign wr_data = {cap_pc, cap_instr};
`endif

   trace_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata (wr_data),
      .raddr (rd_ptr),
      .rdata (rd_data)
   );

   assign state    = st_q;
   assign rd_valid = rd_valid_q;
   assign rd_last  = rd_valid_q & is_newest;
   assign rd_pc    = rd_valid_q ? rd_data[ILEN +: XLEN] : '0;
   assign rd_instr = rd_valid_q ? rd_data[ILEN-1:0]     : '0;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// tb/tb_pipe_trace_buffer.sv - self-checking bench for pipe_trace_buffer (DEPTH=8)
module tb_pipe_trace_buffer;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic        arm = 1'b0;
   logic [31:0] trig_pc = '0;
   logic [7:0]  post_cnt = '0;
   logic        cap_valid = 1'b0;
   logic [31:0] cap_pc = '0;
   logic [31:0] cap_instr = '0;
   logic        rd_ready = 1'b0;
   logic        rd_valid, rd_last, overflow;
   logic [31:0] rd_pc, rd_instr;
   logic [1:0]  state;
   logic [3:0]  count;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   pipe_trace_buffer #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH), .CNTW(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .arm       (arm),
      .trig_pc   (trig_pc),
      .post_cnt  (post_cnt),
      .cap_valid (cap_valid),
      .cap_pc    (cap_pc),
      .cap_instr (cap_instr),
      .rd_ready  (rd_ready),
      .rd_valid  (rd_valid),
      .rd_pc     (rd_pc),
      .rd_instr  (rd_instr),
      .rd_last   (rd_last),
      .state     (state),
      .count     (count),
      .overflow  (overflow)
   );

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return {pc[15:0] ^ 16'h5A5A, 16'h0013};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Behavioural model: the trace window is a plain queue of captured entries.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t m_q[$];
   int   m_st = 0;
   int   m_rem = 0;
   int   m_idx = 0;
   bit   m_ovf = 0;
   bit   m_rdv = 0;

   task automatic model_reset();
      m_q.delete();
      m_st = 0; m_rem = 0; m_idx = 0; m_ovf = 0; m_rdv = 0;
   endtask

   task automatic model_step();
      ent_t e;
      if (arm) begin
         m_q.delete();
         m_st = 1; m_rem = 0; m_idx = 0; m_ovf = 0; m_rdv = 0;
      end else if (m_st == 1 || m_st == 2) begin
         if (enable && cap_valid) begin
            e.pc = cap_pc;
            e.instr = cap_instr;
            m_q.push_back(e);
            if (m_q.size() > DEPTH) begin
               void'(m_q.pop_front());
               m_ovf = 1;
            end
            if (m_st == 1) begin
               if (cap_pc == trig_pc) begin
                  if (post_cnt == 0) m_st = 3;
                  else begin
                     m_st = 2;
                     m_rem = int'(post_cnt);
                  end
               end
            end else begin
               m_rem--;
               if (m_rem == 0) m_st = 3;
            end
         end
      end else if (m_st == 3) begin
         if (!m_rdv) begin
            m_rdv = 1;
            m_idx = 0;
         end else if (rd_ready) begin
            if (m_idx == m_q.size() - 1) begin
               m_st = 0;
               m_rdv = 0;
            end else begin
               m_idx++;
            end
         end
      end
   endtask

   always @(posedge clk) begin
      if (rst) model_step();
   end

   always @(negedge clk) begin
      logic [31:0] e_pc, e_in;
      logic        e_last;
      e_pc = '0; e_in = '0; e_last = 1'b0;
      if (m_rdv) begin
         e_pc = m_q[m_idx].pc;
         e_in = m_q[m_idx].instr;
         e_last = (m_idx == m_q.size() - 1);
      end
      check("state", 32'(state), 32'(m_st));
      check("count", 32'(count), 32'(m_q.size()));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("rd_valid", 32'(rd_valid), 32'(m_rdv));
      check("rd_pc", rd_pc, e_pc);
      check("rd_instr", rd_instr, e_in);
      check("rd_last", 32'(rd_last), 32'(e_last));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic write(input logic [31:0] pc);
      cap_valid = 1'b1;
      cap_pc = pc;
      cap_instr = instr_of(pc);
      tick();
      cap_valid = 1'b0;
   endtask

   task automatic readout(input string tag, input logic [31:0] e[$]);
      int  w;
      bit  dead;
      dead = 0;
      rd_ready = 1'b1;
      foreach (e[i]) begin
         if (!dead) begin
            w = 0;
            while (!rd_valid && w < 20) begin
               tick();
               w++;
            end
            if (!rd_valid) begin
               check({tag, "_wait_valid"}, 32'(rd_valid), 32'd1);
               dead = 1;
            end else begin
               check({tag, "_pc"}, rd_pc, e[i]);
               check({tag, "_instr"}, rd_instr, instr_of(e[i]));
               check({tag, "_last"}, 32'(rd_last), 32'(i == e.size() - 1));
               tick();
            end
         end
      end
      rd_ready = 1'b0;
      check({tag, "_end_state"}, 32'(state), 32'd0);
      check({tag, "_end_valid"}, 32'(rd_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] e[$];
      model_reset();
      repeat (2) tick();
      check("rst_state", 32'(state), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      rst = 1'b1;
      enable = 1'b1;
      tick();

      // basic trigger: trigger at 0x14, two entries after it
      trig_pc = 32'h14; post_cnt = 8'd2;
      do_arm();
      check("basic_armed", 32'(state), 32'd1);
      for (int p = 0; p <= 32'h1C; p += 4) write(32'(p));
      check("basic_done", 32'(state), 32'd3);
      check("basic_count", 32'(count), 32'd8);
      check("basic_ovf", 32'(overflow), 32'd0);
      check("basic_valid_lat", 32'(rd_valid), 32'd0);
      e = {32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C};
      readout("basic", e);

      // wrap: 17 entries into 8 slots, trigger on the last with post_cnt=0
      trig_pc = 32'h40; post_cnt = 8'd0;
      do_arm();
      for (int p = 0; p <= 32'h40; p += 4) write(32'(p));
      check("wrap_done", 32'(state), 32'd3);
      check("wrap_ovf", 32'(overflow), 32'd1);
      check("wrap_count", 32'(count), 32'd8);
      e = {32'h24, 32'h28, 32'h2C, 32'h30, 32'h34, 32'h38, 32'h3C, 32'h40};
      readout("wrap", e);

      // backpressure: hold readout for three cycles
      trig_pc = 32'h08; post_cnt = 8'd1;
      do_arm();
      check("bp_ovf_cleared", 32'(overflow), 32'd0);
      for (int p = 0; p <= 32'h0C; p += 4) write(32'(p));
      check("bp_done", 32'(state), 32'd3);
      tick();
      for (int k = 0; k < 3; k++) begin
         check("bp_hold_valid", 32'(rd_valid), 32'd1);
         check("bp_hold_pc", rd_pc, 32'h00);
         tick();
      end
      e = {32'h00, 32'h04, 32'h08, 32'h0C};
      readout("bp", e);

      // collision: arm together with a matching capture
      trig_pc = 32'h100; post_cnt = 8'd0;
      arm = 1'b1; cap_valid = 1'b1; cap_pc = 32'h100; cap_instr = instr_of(32'h100);
      tick();
      arm = 1'b0; cap_valid = 1'b0;
      check("coll_state", 32'(state), 32'd1);
      check("coll_count", 32'(count), 32'd0);

      // enable low blocks capture and trigger
      enable = 1'b0;
      cap_valid = 1'b1; cap_pc = 32'h100; cap_instr = instr_of(32'h100);
      repeat (2) tick();
      cap_valid = 1'b0;
      check("en_state", 32'(state), 32'd1);
      check("en_count", 32'(count), 32'd0);
      enable = 1'b1;
      write(32'h00);
      trig_pc = 32'h10; post_cnt = 8'd3;
      write(32'h10);
      write(32'h14);
      check("post_state", 32'(state), 32'd2);
      check("post_count", 32'(count), 32'd3);

      // asynchronous reset in the middle of POST
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      check("arst_state", 32'(state), 32'd0);
      check("arst_count", 32'(count), 32'd0);
      check("arst_ovf", 32'(overflow), 32'd0);
      check("arst_valid", 32'(rd_valid), 32'd0);
      tick();
      rst = 1'b1;
      tick();

      // capture resumes after re-arm
      trig_pc = 32'h10; post_cnt = 8'd0;
      do_arm();
      write(32'h0C);
      write(32'h10);
      check("rearm_done", 32'(state), 32'd3);
      check("rearm_count", 32'(count), 32'd2);
      e = {32'h0C, 32'h10};
      readout("rearm", e);

      repeat (2) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
